// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port
//                synchronous RAM. Each grant performs one read or one write;
//                read data is captured one cycle after the RAM access and
//                returned on a shared rdata bus with a per-port rvalid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*AWIDTH-1:0] addr,
   input  logic [2*DWIDTH-1:0] wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          rvalid,
   output logic [DWIDTH-1:0]   rdata,
   output logic                busy,
   output logic [AWIDTH-1:0]   mem_addr,
   output logic                mem_rdEn,
   output logic                mem_wrEn,
   output logic [DWIDTH-1:0]   mem_wdata,
   input  logic [DWIDTH-1:0]   mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t state;

   // Last-granted requester; a tie goes to the other one.
   logic last_ptr;
   // Requester owning the transaction in flight and its direction.
   logic cur_idx;
   logic cur_we;

   // Requester chosen if a grant happens this cycle.
   logic              sel;
   logic [AWIDTH-1:0] sel_addr;
   logic [DWIDTH-1:0] sel_wdata;
   logic              sel_we;

   // Round-robin choice: a lone request wins outright, a tie alternates.
   always_comb begin
      sel = 1'b0;
      if (req == 2'b11) begin
         sel = ~last_ptr;
      end else begin
         sel = req[1];
      end
      sel_addr  = sel ? addr[2*AWIDTH-1:AWIDTH]  : addr[AWIDTH-1:0];
      sel_wdata = sel ? wdata[2*DWIDTH-1:DWIDTH] : wdata[DWIDTH-1:0];
      sel_we    = sel ? we[1] : we[0];
   end

   // Transaction FSM; every output is a register updated alongside state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last_ptr  <= 1'b1;
         cur_idx   <= 1'b0;
         cur_we    <= 1'b0;
         gnt       <= 2'b00;
         rvalid    <= 2'b00;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_rdEn  <= 1'b0;
         mem_wrEn  <= 1'b0;
         mem_wdata <= '0;
      end else begin
         // Pulses default low; each state raises only what it owns.
         gnt      <= 2'b00;
         rvalid   <= 2'b00;
         mem_rdEn <= 1'b0;
         mem_wrEn <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt       <= sel ? 2'b10 : 2'b01;
                  last_ptr  <= sel;
                  cur_idx   <= sel;
                  cur_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_wrEn  <= sel_we;
                  mem_rdEn  <= ~sel_we;
                  busy      <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // The RAM sees its enable on this edge; writes are finished.
               if (cur_we) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               rdata  <= mem_rdata;
               rvalid <= cur_idx ? 2'b10 : 2'b01;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a behavioural RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [1:0]      req = '0;
   logic [1:0]      we = '0;
   logic [2*AW-1:0] addr = '0;
   logic [2*DW-1:0] wdata = '0;
   logic [1:0]      gnt;
   logic [1:0]      rvalid;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic [AW-1:0]   mem_addr;
   logic            mem_rdEn;
   logic            mem_wrEn;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata = '0;

   logic [DW-1:0]   ram [0:(1<<AW)-1];

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] last_rdata = '0;

   mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .busy(busy), .mem_addr(mem_addr), .mem_rdEn(mem_rdEn),
      .mem_wrEn(mem_wrEn), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after mem_rdEn is sampled.
   always @(posedge clk) begin
      if (mem_wrEn) ram[mem_addr] <= mem_wdata;
      if (mem_rdEn) mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      logic [1:0]    req;
      logic [1:0]    we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] wd0;
      logic [DW-1:0] wd1;
      logic          port;   // expected winner
      logic [DW-1:0] rd;     // expected read data (reads only)
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 2'b00;
      tick();
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [1:0] eg;
      logic       ew;
      req   = v.req;
      we    = v.we;
      addr  = {v.a1, v.a0};
      wdata = {v.wd1, v.wd0};
      eg = v.port ? 2'b10 : 2'b01;
      ew = v.port ? v.we[1] : v.we[0];
      tick();  // grant edge
      chk("vec_gnt", gnt, eg);
      chk("vec_mem_addr", mem_addr, v.port ? v.a1 : v.a0);
      chk("vec_wrEn", mem_wrEn, ew);
      chk("vec_rdEn", mem_rdEn, !ew);
      chk("vec_busy_grant", busy, 1);
      if (ew) chk("vec_mem_wdata", mem_wdata, v.port ? v.wd1 : v.wd0);
      req = 2'b00;
      tick();  // access edge
      chk("vec_gnt_pulse", gnt, 0);
      chk("vec_en_clear", {mem_rdEn, mem_wrEn}, 0);
      chk("vec_rvalid_early", rvalid, 0);
      if (ew) begin
         chk("vec_busy_wr_done", busy, 0);
         chk("vec_rdata_hold", rdata, last_rdata);
      end else begin
         chk("vec_busy_rd", busy, 1);
         tick();  // capture edge
         chk("vec_rvalid", rvalid, eg);
         chk("vec_rdata", rdata, v.rd);
         chk("vec_busy_rd_done", busy, 0);
         last_rdata = v.rd;
         tick();
         chk("vec_rvalid_pulse", rvalid, 0);
      end
   endtask

   initial begin
      int ngr;
      for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
      ram[5]    = 32'hDEADBEEF;
      ram[9]    = 32'hCAFEF00D;
      ram[1023] = 32'h0BADF00D;

      //          req    we     a0   a1    wd0           wd1           port  rd
      vecs[0] = '{2'b01, 2'b00, 5,   0,    0,            0,            1'b0, 32'hDEADBEEF};
      vecs[1] = '{2'b10, 2'b10, 0,   7,    0,            32'h12345678, 1'b1, 0};
      vecs[2] = '{2'b01, 2'b00, 7,   0,    0,            0,            1'b0, 32'h12345678};
      vecs[3] = '{2'b11, 2'b00, 3,   9,    0,            0,            1'b1, 32'hCAFEF00D};
      vecs[4] = '{2'b11, 2'b11, 12,  13,   32'hA5A5A5A5, 32'h11111111, 1'b0, 0};
      vecs[5] = '{2'b11, 2'b00, 12,  5,    0,            0,            1'b1, 32'hDEADBEEF};
      vecs[6] = '{2'b11, 2'b00, 12,  5,    0,            0,            1'b0, 32'hA5A5A5A5};
      vecs[7] = '{2'b10, 2'b00, 0,   1023, 0,            0,            1'b1, 32'h0BADF00D};

      // Reset state
      do_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_en", {mem_rdEn, mem_wrEn}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);

      // Idle with no requests
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_busy", busy, 0);
         chk("idle_en", {mem_rdEn, mem_wrEn, gnt}, 0);
      end

      // Table-driven transactions
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Inputs changing during ACCESS/CAPTURE are ignored
      do_reset();
      req = 2'b01; we = 2'b00; addr = {10'd0, 10'd5};
      tick();
      chk("tog_gnt0", gnt, 2'b01);
      req = 2'b10; we = 2'b10; addr = {10'd20, 10'd5}; wdata = {32'h55AA55AA, 32'h0};
      tick();
      chk("tog_access_gnt", gnt, 0);
      chk("tog_access_en", {mem_rdEn, mem_wrEn}, 0);
      chk("tog_access_addr", mem_addr, 5);
      req = 2'b11;
      tick();
      chk("tog_capture_gnt", gnt, 0);
      chk("tog_capture_wrEn", mem_wrEn, 0);
      chk("tog_capture_addr", mem_addr, 5);
      chk("tog_capture_rvalid", rvalid, 2'b01);
      req = 2'b10;
      tick();
      chk("tog_next_gnt", gnt, 2'b10);
      chk("tog_next_wrEn", mem_wrEn, 1);
      chk("tog_next_addr", mem_addr, 20);
      req = 2'b00;
      tick();
      chk("tog_done_busy", busy, 0);

      // Both requesting continuously, all reads
      do_reset();
      req = 2'b11; we = 2'b00; addr = {10'd9, 10'd5};
      for (int k = 1; k <= 12; k++) begin
         logic [1:0] eg;
         logic [1:0] ev;
         tick();
         eg = 2'b00;
         ev = 2'b00;
         if (k % 3 == 1) eg = (((k - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
         if (k % 3 == 0) ev = (((k - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
         chk("rr_gnt", gnt, eg);
         chk("rr_rvalid", rvalid, ev);
         chk("rr_rdEn", mem_rdEn, (k % 3 == 1));
         if (ev == 2'b01) chk("rr_rdata0", rdata, 32'hDEADBEEF);
         if (ev == 2'b10) chk("rr_rdata1", rdata, 32'hCAFEF00D);
      end
      req = 2'b00;
      tick(); tick(); tick();

      // No starvation: req1 joins after the first grant
      do_reset();
      req = 2'b01; we = 2'b00; addr = {10'd9, 10'd5};
      ngr = 0;
      for (int c = 0; c < 60 && ngr < 6; c++) begin
         tick();
         if (gnt != 2'b00) begin
            chk("fair_gnt", gnt, (ngr % 2 == 0) ? 2'b01 : 2'b10);
            ngr++;
            if (ngr == 1) req = 2'b11;
         end
      end
      chk("fair_count", ngr, 6);
      req = 2'b00;
      tick(); tick(); tick();

      // Reset in CAPTURE aborts the read
      do_reset();
      req = 2'b01; we = 2'b00; addr = {10'd0, 10'd5};
      tick();
      chk("abc_gnt", gnt, 2'b01);
      req = 2'b00;
      tick();
      chk("abc_busy", busy, 1);
      reset = 1'b1;
      tick();
      chk("abc_rvalid", rvalid, 0);
      chk("abc_rdata", rdata, 0);
      chk("abc_busy_clr", busy, 0);
      reset = 1'b0;
      tick();
      chk("abc_rvalid_after", rvalid, 0);
      req = 2'b11;
      tick();
      chk("abc_next_gnt", gnt, 2'b01);
      req = 2'b00;
      tick(); tick(); tick();

      // Reset in ACCESS aborts, and reset beats a simultaneous request
      do_reset();
      req = 2'b10; we = 2'b00; addr = {10'd9, 10'd0};
      tick();
      chk("aba_gnt", gnt, 2'b10);
      req = 2'b11;
      reset = 1'b1;
      tick();
      chk("aba_en", {mem_rdEn, mem_wrEn}, 0);
      chk("aba_gnt_rst", gnt, 0);
      chk("aba_busy", busy, 0);
      reset = 1'b0;
      req = 2'b00;
      tick();
      chk("aba_rvalid1", rvalid, 0);
      tick();
      chk("aba_rvalid2", {rvalid, mem_rdEn}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound on simulation time
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
